// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle multiply/divide unit that owns the HI/LO registers.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   start_i, op_i     launch MULT(00) / MULTU(01) / DIV(10) / DIVU(11)
//   rs_i, rt_i        operand A (multiplicand/dividend), operand B (multiplier/divisor)
//   mthi_i, mtlo_i    write wdata_i into HI / LO while idle
//   wdata_i           MTHI/MTLO data
//   cancel_i          abort an operation in flight, no commit
//   hi_o, lo_o        HI / LO registers
//   busy_o            operation in flight (RUN or DONE)
//   done_o            one-cycle pulse when the result is committed
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        mthi_i,
  input  logic        mtlo_i,
  input  logic [31:0] wdata_i,
  input  logic        cancel_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] rs_q, rs_d;         // raw dividend, kept for divide-by-zero and signs
  logic        rt_neg_q, rt_neg_d; // operand B was negative (signed ops only)
  logic [31:0] mb_q, mb_d;         // |operand B|
  logic [63:0] acc_q, acc_d;       // mult: {partial product, multiplier}; div: [31:0] dividend/quotient
  logic [32:0] rem_q, rem_d;       // divide partial remainder
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        busy_q, busy_d, done_q, done_d;

  logic        in_signed, is_signed, neg_res;
  logic [31:0] ma_in, mb_in, quo, rmd;
  logic [32:0] sum, rem_sh, rem_sub, rem_nx;
  logic [63:0] acc_nx, prod;
  logic        unused_rem_msb;

  // Remainder stays below the divisor, so its top bit is only headroom.
  assign unused_rem_msb = rem_q[32];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rs_d     = rs_q;
    rt_neg_d = rt_neg_q;
    mb_d     = mb_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    in_signed = ~op_i[0];
    ma_in     = (in_signed && rs_i[31]) ? -rs_i : rs_i;
    mb_in     = (in_signed && rt_i[31]) ? -rt_i : rt_i;

    // One iteration of either datapath; only the one matching op_q is used.
    sum     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mb_q} : 33'd0);
    rem_sh  = {rem_q[31:0], acc_q[31]};
    rem_sub = rem_sh - {1'b0, mb_q};
    if (op_q[1]) begin
      if (rem_sh >= {1'b0, mb_q}) begin
        rem_nx = rem_sub;
        acc_nx = {acc_q[63:32], acc_q[30:0], 1'b1};
      end else begin
        rem_nx = rem_sh;
        acc_nx = {acc_q[63:32], acc_q[30:0], 1'b0};
      end
    end else begin
      rem_nx = rem_q;
      acc_nx = {sum, acc_q[31:1]};
    end

    // Sign fix-up applied to the final iteration's value at commit.
    is_signed = ~op_q[0];
    neg_res   = is_signed && (rs_q[31] ^ rt_neg_q);
    prod      = neg_res ? -acc_nx : acc_nx;
    quo       = neg_res ? -acc_nx[31:0] : acc_nx[31:0];
    rmd       = (is_signed && rs_q[31]) ? -rem_nx[31:0] : rem_nx[31:0];

    case (state_q)
      IDLE: begin
        if (mthi_i) hi_d = wdata_i;
        if (mtlo_i) lo_d = wdata_i;
        if (start_i) begin
          state_d  = RUN;
          cnt_d    = '0;
          op_d     = op_i;
          rs_d     = rs_i;
          rt_neg_d = in_signed & rt_i[31];
          mb_d     = mb_in;
          acc_d    = {32'd0, ma_in};
          rem_d    = '0;
        end
      end
      RUN: begin
        if (cancel_i) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_nx;
          rem_d = rem_nx;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = DONE;
            if (op_q[1]) begin
              if (mb_q == '0) begin
                hi_d = rs_q;
                lo_d = '1;
              end else begin
                hi_d = rmd;
                lo_d = quo;
              end
            end else begin
              hi_d = prod[63:32];
              lo_d = prod[31:0];
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rs_q     <= '0;
      rt_neg_q <= 1'b0;
      mb_q     <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rs_q     <= rs_d;
      rt_neg_q <= rt_neg_d;
      mb_q     <= mb_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed and randomized checks of muldiv_ctrl against an
// arithmetic reference model.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = '0;
  logic [31:0] rs_i = '0;
  logic [31:0] rt_i = '0;
  logic        mthi_i = 1'b0;
  logic        mtlo_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic        cancel_i = 1'b0;
  logic [31:0] hi_o, lo_o;
  logic        busy_o, done_o;

  int checks = 0;
  int errors = 0;

  muldiv_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .rs_i(rs_i), .rt_i(rt_i),
    .mthi_i(mthi_i), .mtlo_i(mtlo_i), .wdata_i(wdata_i), .cancel_i(cancel_i),
    .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge: outputs then show the new cycle.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Reference result {HI, LO} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: res = sa * sb;
      2'b01: res = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  // Start in cycle T and follow through T+34.
  // opt[0]: MTHI in the start cycle; opt[1]: start/MTHI/MTLO poke at T+5;
  // opt[2]: cancel_i during DONE.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] opt);
    logic [63:0] exp;
    logic [31:0] w;
    exp = model(op, a, b);
    w = $urandom;
    chk({tag, " idle busy"}, 64'(busy_o), 64'd0);
    start_i = 1'b1; op_i = op; rs_i = a; rt_i = b;
    if (opt[0]) begin mthi_i = 1'b1; wdata_i = w; end
    next();
    start_i = 1'b0; mthi_i = 1'b0;
    op_i = 2'($urandom); rs_i = $urandom; rt_i = $urandom;
    for (int i = 1; i <= 32; i++) begin
      chk({tag, " run busy"}, 64'(busy_o), 64'd1);
      chk({tag, " run done"}, 64'(done_o), 64'd0);
      if (i == 1 && opt[0]) chk({tag, " mthi at start"}, 64'(hi_o), 64'(w));
      if (i == 5 && opt[1]) begin
        start_i = 1'b1; mthi_i = 1'b1; mtlo_i = 1'b1; wdata_i = ~w; op_i = ~op;
      end
      if (i == 6) begin start_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0; end
      next();
    end
    chk({tag, " done"}, 64'(done_o), 64'd1);
    chk({tag, " done busy"}, 64'(busy_o), 64'd1);
    chk({tag, " result"}, {hi_o, lo_o}, exp);
    if (opt[2]) cancel_i = 1'b1;
    next();
    cancel_i = 1'b0;
    chk({tag, " after done"}, 64'(done_o), 64'd0);
    chk({tag, " after busy"}, 64'(busy_o), 64'd0);
    chk({tag, " held"}, {hi_o, lo_o}, exp);
  endtask

  initial begin
    int pulses;
    logic [31:0] a, b;
    logic [1:0]  op;

    // Reset wins over every other request.
    rst = 1'b1; start_i = 1'b1; mthi_i = 1'b1; mtlo_i = 1'b1; wdata_i = 32'hDEAD_BEEF; cancel_i = 1'b1;
    next();
    next();
    rst = 1'b0; start_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0; cancel_i = 1'b0;
    chk("reset hi", 64'(hi_o), 64'd0);
    chk("reset lo", 64'(lo_o), 64'd0);
    chk("reset busy", 64'(busy_o), 64'd0);
    chk("reset done", 64'(done_o), 64'd0);
    next();
    chk("idle after reset", 64'(busy_o), 64'd0);

    // Directed cases.
    run_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000);
    chk("multu max const", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);
    run_op("mult -2*3", 2'b00, 32'hFFFF_FFFE, 32'd3, 3'b001);
    chk("mult -2*3 const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 3'b100);
    chk("div -7/2 const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu 7/0", 2'b11, 32'd7, 32'd0, 3'b000);
    chk("divu 7/0 const", {hi_o, lo_o}, 64'h0000_0007_FFFF_FFFF);
    run_op("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 3'b000);
    chk("div min/-1 const", {hi_o, lo_o}, 64'h0000_0000_8000_0000);
    run_op("div neg/0", 2'b10, 32'hFFFF_FF00, 32'd0, 3'b000);
    run_op("mult min*min", 2'b00, 32'h8000_0000, 32'h8000_0000, 3'b000);
    run_op("div 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 3'b000);

    // Start and MTHI/MTLO during RUN are ignored.
    run_op("ignore poke", 2'b01, 32'h0001_0003, 32'h0000_0101, 3'b010);

    // MTLO, then cancel mid-RUN: back to IDLE with LO intact, no done.
    mtlo_i = 1'b1; wdata_i = 32'h1234_5678;
    next();
    mtlo_i = 1'b0;
    chk("mtlo write", 64'(lo_o), 64'h1234_5678);
    start_i = 1'b1; op_i = 2'b01; rs_i = 32'h0000_0009; rt_i = 32'h0000_0005;
    next();
    start_i = 1'b0;
    for (int i = 1; i < 10; i++) next();
    cancel_i = 1'b1;
    next();
    cancel_i = 1'b0;
    chk("cancel busy", 64'(busy_o), 64'd0);
    chk("cancel done", 64'(done_o), 64'd0);
    chk("cancel lo", 64'(lo_o), 64'h1234_5678);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (done_o) pulses++;
      next();
    end
    chk("cancel no done", 64'(pulses), 64'd0);
    chk("cancel lo later", 64'(lo_o), 64'h1234_5678);

    // Reset mid-RUN aborts with no commit.
    mthi_i = 1'b1; mtlo_i = 1'b1; wdata_i = 32'hA5A5_5A5A;
    next();
    mthi_i = 1'b0; mtlo_i = 1'b0;
    chk("mt both", {hi_o, lo_o}, 64'hA5A5_5A5A_A5A5_5A5A);
    start_i = 1'b1; op_i = 2'b10; rs_i = 32'd100; rt_i = 32'd7;
    next();
    start_i = 1'b0;
    for (int i = 1; i < 20; i++) next();
    rst = 1'b1;
    next();
    rst = 1'b0;
    chk("midrun rst busy", 64'(busy_o), 64'd0);
    chk("midrun rst done", 64'(done_o), 64'd0);
    chk("midrun rst hilo", {hi_o, lo_o}, 64'd0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (done_o) pulses++;
      next();
    end
    chk("midrun rst no done", 64'(pulses), 64'd0);

    // Randomized operations with a bias toward zero/small/extreme divisors.
    for (int n = 0; n < 24; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 9);
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run_op("random", op, a, b, 3'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
